// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 hex keypad scanner.
//   - state_t     : scanner FSM states (SCAN, PRESS_DB, HELD)
//   - ROWS_IDLE   : synchronized row pattern when no key is down
//   - KEY_MAP     : 16-entry key map, entry {row,col} holds the hex code
//   - helpers     : hit detection, row decoding, column drive pattern
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Nibble n (n = row*4 + col) holds the key code; entry 0 is the LSB nibble.
    //   row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] idx;
        idx = {r, c, 2'b00};
        return KEY_MAP[idx +: 4];
    endfunction

    // A valid hit has exactly one row line pulled low.
    function automatic logic is_hit(input logic [3:0] p);
        return (p == 4'b1110) || (p == 4'b1101) || (p == 4'b1011) || (p == 4'b0111);
    endfunction

    // Only meaningful for patterns accepted by is_hit.
    function automatic logic [1:0] row_index(input logic [3:0] p);
        logic [1:0] r;
        case (p)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer, one independent chain per bit.
//   clk   : system clock
//   reset : synchronous active-high, loads RESET_VAL into both stages
//   d     : asynchronous input bus (W bits)
//   q     : synchronized output bus (W bits)
module sync2 #(
    parameter int             W         = 4,
    parameter logic [W-1:0]   RESET_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic s1_reg;
            logic s2_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg <= RESET_VAL[gi];
                    s2_reg <= RESET_VAL[gi];
                end else begin
                    s1_reg <= d[gi];
                    s2_reg <= s1_reg;
                end
            end

            assign q[gi] = s2_reg;
        end
    endgenerate

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 hex keypad, debounces presses and releases, and
// shifts accepted keys into a two-digit entry register {previous, latest}.
//   clk       : system clock
//   reset     : synchronous active-high
//   rows      : row lines, active-low, asynchronous (synchronized internally)
//   cols      : column drive, active-low, exactly one bit low
//   key_valid : one-cycle pulse per accepted press
//   key_code  : code of the last accepted key, held between pulses
//   value     : {previous, latest} entry register for the display driver
// Build option: define KEYPAD_CLEAR_EN to make key C clear value to 8'h00.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] value
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE);

    logic [3:0]    rs;
    state_t        state_reg;
    logic [1:0]    col_reg;
    logic [3:0]    cols_reg;
    logic [DW-1:0] dwell_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]    row_pat_reg;
    logic          key_valid_reg;
    logic [3:0]    key_code_reg;
    logic [7:0]    value_reg;

    logic          sample;
    logic          hit;
    logic [3:0]    accept_code;
    logic [7:0]    value_next;
    logic [CW-1:0] cnt_inc;

    sync2 #(
        .W         (4),
        .RESET_VAL (ROWS_IDLE)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rs)
    );

    assign sample  = (dwell_reg == DWELL_LAST);
    assign hit     = is_hit(rs);
    assign cnt_inc = cnt_reg + CW'(1);

    // Whenever an accept happens, rs is the hit pattern of the held column,
    // so the code can be taken straight from rs and the current column.
    always_comb begin
        accept_code = key_lookup(row_index(rs), col_reg);
`ifdef KEYPAD_CLEAR_EN
        value_next = (accept_code == 4'hC) ? 8'h00 : {value_reg[3:0], accept_code};
`else
        value_next = {value_reg[3:0], accept_code};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            cols_reg      <= 4'b1110;
            dwell_reg     <= '0;
            cnt_reg       <= '0;
            row_pat_reg   <= ROWS_IDLE;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'h0;
            value_reg     <= 8'h00;
        end else begin
            key_valid_reg <= 1'b0;
            dwell_reg     <= sample ? '0 : dwell_reg + DW'(1);

            if (sample) begin
                case (state_reg)
                    SCAN: begin
                        if (hit) begin
                            row_pat_reg <= rs;
                            if (DEBOUNCE == 1) begin
                                key_valid_reg <= 1'b1;
                                key_code_reg  <= accept_code;
                                value_reg     <= value_next;
                                cnt_reg       <= '0;
                                state_reg     <= HELD;
                            end else begin
                                cnt_reg   <= CW'(1);
                                state_reg <= PRESS_DB;
                            end
                        end else begin
                            col_reg  <= col_reg + 2'd1;
                            cols_reg <= col_drive(col_reg + 2'd1);
                        end
                    end

                    PRESS_DB: begin
                        if (rs == row_pat_reg) begin
                            if (cnt_inc == DB_TARGET) begin
                                key_valid_reg <= 1'b1;
                                key_code_reg  <= accept_code;
                                value_reg     <= value_next;
                                cnt_reg       <= '0;
                                state_reg     <= HELD;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end else begin
                            // Bounce: give up on this key and move on.
                            cnt_reg   <= '0;
                            col_reg   <= col_reg + 2'd1;
                            cols_reg  <= col_drive(col_reg + 2'd1);
                            state_reg <= SCAN;
                        end
                    end

                    HELD: begin
                        // Invalid multi-row patterns count as idle here too.
                        if (hit) begin
                            cnt_reg <= '0;
                        end else if (cnt_inc == DB_TARGET) begin
                            cnt_reg   <= '0;
                            col_reg   <= col_reg + 2'd1;
                            cols_reg  <= col_drive(col_reg + 2'd1);
                            state_reg <= SCAN;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end

                    default: begin
                        cnt_reg   <= '0;
                        state_reg <= SCAN;
                    end
                endcase
            end
        end
    end

    assign cols      = cols_reg;
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign value     = value_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3).
// A keypad model pulls a row low whenever a pressed key sits in the driven
// column. Each press long enough to be accepted pushes its expected
// {key_code, value} into a scoreboard; a monitor pops and compares on every
// key_valid pulse. Honours KEYPAD_CLEAR_EN for the expected value of key C.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    typedef struct {
        logic [3:0] code;
        logic [7:0] value;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] value;

    logic [15:0] pressed = '0;
    logic [7:0]  model_value = 8'h00;
    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Physical key legend, indexed row*4 + col.
    logic [3:0] keymap [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value)
    );

    // Keypad matrix: a pressed key shorts its row to its column.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'(key_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("pulse key_code=%h value=%h expected code=%h value=%h",
                         key_code, value, e.code, e.value);
                check("key_code", 32'(key_code), 32'(e.code));
                check("value", 32'(value), 32'(e.value));
            end
        end
    end

    task automatic expect_key(input int r, input int c);
        exp_t e;
        e.code = keymap[r*4 + c];
`ifdef KEYPAD_CLEAR_EN
        if (e.code == 4'hC) model_value = 8'h00;
        else                model_value = {model_value[3:0], e.code};
`else
        model_value = {model_value[3:0], e.code};
`endif
        e.value = model_value;
        sb_q.push_back(e);
    endtask

    task automatic idle_gap(input int n);
        pressed = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_check(input string name);
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic long_press(input int r, input int c);
        $display("press key r=%0d c=%0d code=%h (long)", r, c, keymap[r*4 + c]);
        expect_key(r, c);
        pressed = '0;
        pressed[r*4 + c] = 1'b1;
        repeat (48) @(negedge clk);
        idle_gap(24);
        drain_check("missed_pulse");
    endtask

    task automatic bounce_press(input int r, input int c, input int hold);
        $display("bounce key r=%0d c=%0d hold=%0d", r, c, hold);
        pressed = '0;
        pressed[r*4 + c] = 1'b1;
        repeat (hold) @(negedge clk);
        idle_gap(24);
    endtask

    task automatic double_press(input int c);
        int r1;
        int r2;
        r1 = $urandom_range(0, 3);
        r2 = (r1 + $urandom_range(1, 3)) % 4;
        $display("double press rows %0d,%0d col=%0d", r1, r2, c);
        pressed = '0;
        pressed[r1*4 + c] = 1'b1;
        pressed[r2*4 + c] = 1'b1;
        repeat (48) @(negedge clk);
        idle_gap(24);
    endtask

    // Reset mid-scan, then watch 20 idle dwells of column rotation.
    task automatic reset_and_rotate();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        $display("mid-scan reset");
        check("rst_cols", 32'(cols), 32'h0000000E);
        check("rst_value", 32'(value), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        model_value = 8'h00;
        sb_q.delete();
        for (int k = 0; k < 20 * SCAN_DIV; k++) begin
            logic [3:0] exp_cols;
            @(negedge clk);
            reset = 1'b0;
            exp_cols = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            if (cols !== exp_cols) check("rotate_cols", 32'(cols), 32'(exp_cols));
            else checks++;
        end
    endtask

    initial begin
        logic [3:0] prev_cols;
        bit         found;

        // Reset values while held in reset.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("init_cols", 32'(cols), 32'h0000000E);
        check("init_key_valid", 32'(key_valid), 32'h0);
        check("init_key_code", 32'(key_code), 32'h0);
        check("init_value", 32'(value), 32'h0);
        reset = 1'b0;

        repeat (6) @(negedge clk);
        reset_and_rotate();

        // Hold 5: one pulse, column stays on col1 while held.
        $display("press key 5 (held check)");
        expect_key(1, 1);
        pressed = '0;
        pressed[5] = 1'b1;
        repeat (36) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("held_cols", 32'(cols), 32'h0000000D);
        end
        idle_gap(24);
        drain_check("missed_pulse_5");

        long_press(0, 3);          // A -> 5A
        check("value_5A", 32'(value), 32'h5A);

        // Directed bounce aligned to the start of a col1 dwell.
        prev_cols = cols;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cols == 4'b1101 && prev_cols != 4'b1101) found = 1'b1;
            prev_cols = cols;
        end
        check("bounce_align", 32'(found), 32'd1);
        $display("bounce key 5 for two samples");
        pressed[5] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k < 12) check("bounce_hold_cols", 32'(cols), 32'h0000000D);
            else        check("bounce_next_cols", 32'(cols), 32'h0000000B);
            if (k == 8) pressed = '0;
        end
        idle_gap(24);

        double_press(1);
        check("value_after_double", 32'(value), 32'h5A);

        long_press(2, 3);          // C
`ifdef KEYPAD_CLEAR_EN
        check("value_after_C", 32'(value), 32'h00);
`else
        check("value_after_C", 32'(value), 32'hAC);
`endif

        reset_and_rotate();

        // Randomized mix of accepted presses, bounces and double presses.
        for (int i = 0; i < 20; i++) begin
            int kind;
            int r;
            int c;
            kind = $urandom_range(0, 9);
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            if (kind < 6)      long_press(r, c);
            else if (kind < 8) bounce_press(r, c, $urandom_range(1, 8));
            else               double_press(c);
        end

        idle_gap(40);
        drain_check("final_queue");
        check("final_value", 32'(value), 32'(model_value));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
